// File: rtl/timer_pkg.sv
// Shared types for the countdown-timer controller: FSM state codes and key indices.
// Latency: n/a (package only).
// Backpressure: n/a.
package timer_pkg;

    // State codes are visible on the controller's state output, so the
    // encoding is fixed rather than left to the tool.
    typedef enum logic [2:0] {
        ST_SET   = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_WARN  = 3'd3,
        ST_DONE  = 3'd4
    } timer_state_t;

    // Bit positions of the keys inside the packed key vector.
    localparam int KEY_INC   = 0;
    localparam int KEY_DEC   = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_RUN   = 4;
    localparam int KEY_CLEAR = 5;
    localparam int NUM_KEYS  = 6;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD nibble stepped up or down by one when cin is set, with carry/borrow out.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   nib_in   current digit (0..9)
//   up/down  step direction; both or neither set leaves the digit unchanged
//   cin      step enable (carry/borrow in from the lower digit, or digit select)
//   nib_out  stepped digit, wrapping 9->0 upwards and 0->9 downwards
//   cout     set when the step wrapped (carry or borrow into the next digit)
module bcd_digit_step (
    input  logic [3:0] nib_in,
    input  logic       up,
    input  logic       down,
    input  logic       cin,
    output logic [3:0] nib_out,
    output logic       cout
);

    always_comb begin
        nib_out = nib_in;
        cout    = 1'b0;
        if (cin && up && !down) begin
            // Non-BCD codes are treated as 9 so the digit recovers to 0.
            if (nib_in >= 4'd9) begin
                nib_out = 4'd0;
                cout    = 1'b1;
            end else begin
                nib_out = nib_in + 4'd1;
            end
        end else if (cin && down && !up) begin
            if (nib_in == 4'd0) begin
                nib_out = 4'd9;
                cout    = 1'b1;
            end else if (nib_in > 4'd9) begin
                nib_out = 4'd9;
            end else begin
                nib_out = nib_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown-timer controller: editable BCD preset, prescaled countdown, display/status outputs.
// Latency: a key press sampled at edge n updates internal state at n; outputs follow at n+1.
// Backpressure: none; keys are sampled every cycle and outputs are free-running registers.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   key_inc/dec               step the selected preset digit
//   key_left/right            move the edit cursor toward MSB / LSB
//   key_run                   start / pause / resume
//   key_clear                 abort to SET and reload the preset
//   bcd_value                 displayed value, packed BCD, digit 0 in the low nibble
//   point_position            static decimal-point enables
//   blink_mask                digits the display driver should blink
//   state, warn, done         FSM state code and status flags
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int                  DIGITS     = 6,
    parameter int                  TICK_DIV   = 10,
    parameter logic [4*DIGITS-1:0] WARN_BCD   = 'h000300,
    parameter logic [DIGITS-1:0]   POINT_MASK = 'b000100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_inc,
    input  logic                  key_dec,
    input  logic                  key_left,
    input  logic                  key_right,
    input  logic                  key_run,
    input  logic                  key_clear,
    output logic [4*DIGITS-1:0]   bcd_value,
    output logic [DIGITS-1:0]     point_position,
    output logic [DIGITS-1:0]     blink_mask,
    output logic [2:0]            state,
    output logic                  warn,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    timer_state_t          state_q, state_d;
    logic [W-1:0]          preset_q, preset_d;
    logic [W-1:0]          count_q, count_d;
    logic [CW-1:0]         cursor_q, cursor_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [NUM_KEYS-1:0]   key_now, key_q, press;

    logic [W-1:0]          bcd_d;
    logic [DIGITS-1:0]     blink_d;

    logic                  counting;
    logic                  tick;
    logic                  edit_up, edit_dn;
    logic [W-1:0]          count_dec;
    logic [W-1:0]          preset_edit;
    logic [DIGITS:0]       borrow;
    logic [DIGITS-1:0]     unused_edit_cout;
    logic                  unused_borrow_top;

    assign key_now = {key_clear, key_run, key_right, key_left, key_dec, key_inc};
    assign press   = key_now & ~key_q;

    // A tick only happens when no higher-priority key claims the cycle,
    // so a run press on the wrap cycle pauses without decrementing.
    assign counting = (state_q == ST_RUN) || (state_q == ST_WARN);
    assign tick     = counting && !press[KEY_CLEAR] && !press[KEY_RUN] && (presc_q == PRE_MAX);

    // inc+dec together cancel out: the digit step sees neither direction.
    assign edit_up = press[KEY_INC] & ~press[KEY_DEC];
    assign edit_dn = press[KEY_DEC] & ~press[KEY_INC];

    // Gating on count!=0 keeps the ripple borrow from wrapping 0 to all-9s.
    assign borrow[0]         = tick && (count_q != '0);
    assign unused_borrow_top = borrow[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        // Countdown chain: each digit borrows from the one below it.
        bcd_digit_step u_count_step (
            .nib_in  (count_q[4*g +: 4]),
            .up      (1'b0),
            .down    (1'b1),
            .cin     (borrow[g]),
            .nib_out (count_dec[4*g +: 4]),
            .cout    (borrow[g+1])
        );

        // Edit path: chain broken, only the digit under the cursor steps,
        // and its wrap does not propagate.
        bcd_digit_step u_edit_step (
            .nib_in  (preset_q[4*g +: 4]),
            .up      (edit_up),
            .down    (edit_dn),
            .cin     (cursor_q == CW'(g)),
            .nib_out (preset_edit[4*g +: 4]),
            .cout    (unused_edit_cout[g])
        );
    end

    // Next-state logic; priority is clear > run > tick > edit keys.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        count_d  = count_q;
        cursor_d = cursor_q;
        presc_d  = presc_q;

        if (press[KEY_CLEAR]) begin
            state_d = ST_SET;
            count_d = preset_q;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_SET: begin
                    if (press[KEY_RUN]) begin
                        // A zero preset would finish instantly, so run is refused.
                        if (preset_q != '0) begin
                            count_d = preset_q;
                            presc_d = '0;
                            state_d = (preset_q <= WARN_BCD) ? ST_WARN : ST_RUN;
                        end
                    end else begin
                        preset_d = preset_edit;
                        if (press[KEY_LEFT] && !press[KEY_RIGHT]) begin
                            cursor_d = (cursor_q == CUR_MAX) ? '0 : cursor_q + 1'b1;
                        end else if (press[KEY_RIGHT] && !press[KEY_LEFT]) begin
                            cursor_d = (cursor_q == '0) ? CUR_MAX : cursor_q - 1'b1;
                        end
                    end
                end

                ST_RUN, ST_WARN: begin
                    if (press[KEY_RUN]) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        count_d = count_dec;
                        // Packed-BCD order matches unsigned order of the nibbles.
                        if (count_dec == '0) begin
                            state_d = ST_DONE;
                        end else if (count_dec <= WARN_BCD) begin
                            state_d = ST_WARN;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end

                ST_PAUSE: begin
                    // Prescaler is left untouched so resume keeps the tick phase.
                    if (press[KEY_RUN]) begin
                        state_d = (count_q <= WARN_BCD) ? ST_WARN : ST_RUN;
                    end
                end

                ST_DONE: begin
                    count_d = '0;
                end

                default: begin
                    state_d = ST_SET;
                end
            endcase
        end
    end

    // Display values derived from the current internal state; registered below.
    always_comb begin
        bcd_d   = count_q;
        blink_d = '0;
        case (state_q)
            ST_SET: begin
                bcd_d   = preset_q;
                blink_d = DIGITS'(1) << cursor_q;
            end
            ST_DONE: begin
                blink_d = '1;
            end
            default: begin
                blink_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SET;
            preset_q       <= '0;
            count_q        <= '0;
            cursor_q       <= '0;
            presc_q        <= '0;
            // All-ones history: a key held through reset is not a press.
            key_q          <= '1;
            state          <= ST_SET;
            bcd_value      <= '0;
            blink_mask     <= DIGITS'(1);
            point_position <= POINT_MASK;
            warn           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            preset_q       <= preset_d;
            count_q        <= count_d;
            cursor_q       <= cursor_d;
            presc_q        <= presc_d;
            key_q          <= key_now;
            state          <= state_q;
            bcd_value      <= bcd_d;
            blink_mask     <= blink_d;
            point_position <= POINT_MASK;
            warn           <= (state_q == ST_WARN);
            done           <= (state_q == ST_DONE);
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed table, hand sequences and random keys vs a decimal model.
// Latency: model outputs lag its state by one edge, as the DUT's registered outputs do.
// Backpressure: n/a.
module tb_countdown_timer_ctrl;

    localparam int ND     = 6;
    localparam int TD     = 10;
    localparam int WARN_V = 300;

    localparam logic [5:0] K_NONE  = 6'b000000;
    localparam logic [5:0] K_INC   = 6'b000001;
    localparam logic [5:0] K_DEC   = 6'b000010;
    localparam logic [5:0] K_LEFT  = 6'b000100;
    localparam logic [5:0] K_RIGHT = 6'b001000;
    localparam logic [5:0] K_RUN   = 6'b010000;
    localparam logic [5:0] K_CLR   = 6'b100000;

    localparam logic [40:0] RST_OUT = {3'd0, 1'b0, 1'b0, 6'b000100, 6'b000001, 24'h000000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_inc = 1'b0, key_dec = 1'b0, key_left = 1'b0;
    logic        key_right = 1'b0, key_run = 1'b0, key_clear = 1'b0;
    logic [23:0] bcd_value;
    logic [5:0]  point_position;
    logic [5:0]  blink_mask;
    logic [2:0]  state;
    logic        warn;
    logic        done;

    countdown_timer_ctrl #(
        .DIGITS     (ND),
        .TICK_DIV   (TD),
        .WARN_BCD   (24'h000300),
        .POINT_MASK (6'b000100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_inc        (key_inc),
        .key_dec        (key_dec),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_run        (key_run),
        .key_clear      (key_clear),
        .bcd_value      (bcd_value),
        .point_position (point_position),
        .blink_mask     (blink_mask),
        .state          (state),
        .warn           (warn),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model kept as plain decimal numbers.
    int         m_state;   // 0 SET, 1 RUN, 2 PAUSE, 3 WARN, 4 DONE
    int         m_count;
    int         m_cursor;
    int         m_presc;
    int         m_dig[ND];
    logic [5:0] m_kq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int preset_val();
        int v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + m_dig[i];
        return v;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [40:0] model_out();
        logic [23:0] b;
        logic [5:0]  bl;
        b  = (m_state == 0) ? to_bcd(preset_val()) : to_bcd(m_count);
        bl = (m_state == 0) ? 6'(1 << m_cursor) : (m_state == 4) ? 6'h3f : 6'h00;
        return {3'(m_state), m_state == 3, m_state == 4, 6'b000100, bl, b};
    endfunction

    task automatic model_step(input logic [5:0] k, input logic r);
        logic [5:0] p;
        int pv;
        if (r) begin
            m_state = 0; m_count = 0; m_cursor = 0; m_presc = 0;
            for (int i = 0; i < ND; i++) m_dig[i] = 0;
            m_kq = '1;
        end else begin
            p    = k & ~m_kq;
            m_kq = k;
            pv   = preset_val();
            if (p[5]) begin
                m_state = 0; m_count = pv; m_presc = 0;
            end else if (m_state == 0) begin
                if (p[4]) begin
                    if (pv != 0) begin
                        m_count = pv; m_presc = 0;
                        m_state = (pv <= WARN_V) ? 3 : 1;
                    end
                end else begin
                    if (p[0] && !p[1]) m_dig[m_cursor] = (m_dig[m_cursor] + 1) % 10;
                    if (p[1] && !p[0]) m_dig[m_cursor] = (m_dig[m_cursor] + 9) % 10;
                    if (p[2] && !p[3]) m_cursor = (m_cursor + 1) % ND;
                    if (p[3] && !p[2]) m_cursor = (m_cursor + ND - 1) % ND;
                end
            end else if (m_state == 1 || m_state == 3) begin
                if (p[4]) m_state = 2;
                else if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (m_count > 0) m_count = m_count - 1;
                    if (m_count == 0) m_state = 4;
                    else if (m_count <= WARN_V) m_state = 3;
                end else m_presc = m_presc + 1;
            end else if (m_state == 2) begin
                if (p[4]) m_state = (m_count <= WARN_V) ? 3 : 1;
            end else begin
                m_count = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance model and DUT, compare every output.
    task automatic cyc(input logic [5:0] k, input logic r);
        logic [40:0] exp;
        exp = r ? RST_OUT : model_out();
        {key_clear, key_run, key_right, key_left, key_dec, key_inc} = k;
        rst = r;
        @(posedge clk);
        model_step(k, r);
        #1;
        chk("model", {state, warn, done, point_position, blink_mask, bcd_value}, exp);
    endtask

    task automatic press(input logic [5:0] k);
        cyc(k, 1'b0);
        cyc(K_NONE, 1'b0);
    endtask

    task automatic do_reset();
        cyc(K_NONE, 1'b1);
        cyc(K_NONE, 1'b0);
    endtask

    // Enters a decimal preset from the post-reset state (preset 0, cursor 0).
    task automatic enter_preset(input int v);
        int t = v;
        for (int i = 0; i < ND; i++) begin
            repeat (t % 10) press(K_INC);
            press(K_LEFT);
            t = t / 10;
        end
    endtask

    typedef struct {
        logic [5:0]  keys;
        logic [23:0] bcd;
        logic [5:0]  blink;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{K_LEFT,          24'h000000, 6'b000010};
        tbl[1]  = '{K_LEFT,          24'h000000, 6'b000100};
        tbl[2]  = '{K_LEFT,          24'h000000, 6'b001000};
        tbl[3]  = '{K_INC,           24'h001000, 6'b001000};
        tbl[4]  = '{K_INC,           24'h002000, 6'b001000};
        tbl[5]  = '{K_DEC,           24'h001000, 6'b001000};
        tbl[6]  = '{K_DEC,           24'h000000, 6'b001000};
        tbl[7]  = '{K_DEC,           24'h009000, 6'b001000};
        tbl[8]  = '{K_INC | K_DEC,   24'h009000, 6'b001000};
        tbl[9]  = '{K_LEFT | K_RIGHT, 24'h009000, 6'b001000};
        tbl[10] = '{K_RIGHT,         24'h009000, 6'b000100};
        tbl[11] = '{K_RIGHT,         24'h009000, 6'b000010};
        tbl[12] = '{K_RIGHT,         24'h009000, 6'b000001};
        tbl[13] = '{K_RIGHT,         24'h009000, 6'b100000};
        tbl[14] = '{K_LEFT,          24'h009000, 6'b000001};
        tbl[15] = '{K_RUN,           24'h009000, 6'b000000};
        tbl[16] = '{K_CLR,           24'h009000, 6'b000001};
        tbl[17] = '{K_INC,           24'h009001, 6'b000001};

        // Reset held two cycles with run held; no start after release.
        cyc(K_RUN, 1'b1);
        cyc(K_RUN, 1'b1);
        repeat (3) cyc(K_RUN, 1'b0);
        chk("rst_state", state, 3'd0);
        chk("rst_bcd", bcd_value, 24'h0);
        chk("rst_blink", blink_mask, 6'b000001);
        chk("rst_point", point_position, 6'b000100);
        chk("rst_flags", {warn, done}, 2'b00);
        cyc(K_NONE, 1'b0);

        // Editing and cursor table.
        for (int i = 0; i < 18; i++) begin
            press(tbl[i].keys);
            chk($sformatf("tbl%0d_bcd", i), bcd_value, tbl[i].bcd);
            chk($sformatf("tbl%0d_blink", i), blink_mask, tbl[i].blink);
        end

        // Short countdown straight into WARN, then DONE.
        do_reset();
        enter_preset(2);
        press(K_RUN);
        chk("t3_warn", {state, warn, bcd_value}, {3'd3, 1'b1, 24'h000002});
        repeat (9) cyc(K_NONE, 1'b0);
        chk("t3_hold", bcd_value, 24'h000002);
        cyc(K_NONE, 1'b0);
        chk("t3_first", bcd_value, 24'h000001);
        repeat (9) cyc(K_NONE, 1'b0);
        chk("t3_prefinal", state, 3'd3);
        cyc(K_NONE, 1'b0);
        chk("t3_done", {state, done, blink_mask, bcd_value}, {3'd4, 1'b1, 6'h3f, 24'h0});
        press(K_RUN);
        chk("t3_run_ignored", state, 3'd4);

        // Clear from DONE reloads the preset.
        press(K_CLR);
        chk("t6_clear", {state, blink_mask, bcd_value}, {3'd0, 6'b000001, 24'h000002});

        // Zero preset refuses to start.
        do_reset();
        press(K_RUN);
        chk("t6_zero_guard", {state, bcd_value}, {3'd0, 24'h0});

        // RUN crosses the warning threshold on the same edge as the count.
        enter_preset(305);
        press(K_RUN);
        chk("t4_run", {state, warn}, {3'd1, 1'b0});
        repeat (48) cyc(K_NONE, 1'b0);
        cyc(K_NONE, 1'b0);
        chk("t4_301", {state, bcd_value}, {3'd1, 24'h000301});
        cyc(K_NONE, 1'b0);
        chk("t4_warn", {state, warn, bcd_value}, {3'd3, 1'b1, 24'h000300});

        // Pause mid-period, hold, resume keeping the prescaler phase.
        do_reset();
        enter_preset(500);
        press(K_RUN);
        repeat (3) cyc(K_NONE, 1'b0);
        press(K_RUN);
        repeat (50) cyc(K_NONE, 1'b0);
        chk("t5_paused", {state, bcd_value}, {3'd2, 24'h000500});
        press(K_RUN);
        chk("t5_resumed", state, 3'd1);
        repeat (4) cyc(K_NONE, 1'b0);
        cyc(K_NONE, 1'b0);
        chk("t5_not_yet", bcd_value, 24'h000500);
        cyc(K_NONE, 1'b0);
        chk("t5_decrement", bcd_value, 24'h000499);

        // Reset mid-run restores everything including the preset.
        cyc(K_NONE, 1'b1);
        chk("midrst_out", {state, blink_mask, bcd_value}, {3'd0, 6'b000001, 24'h0});
        cyc(K_NONE, 1'b0);
        chk("midrst_preset", bcd_value, 24'h0);

        // Run and clear together: clear wins.
        enter_preset(500);
        press(K_RUN);
        repeat (3) cyc(K_NONE, 1'b0);
        press(K_RUN | K_CLR);
        chk("t6_run_clear", {state, bcd_value}, {3'd0, 24'h000500});

        // Random key traffic against the model.
        for (int r = 0; r < 6; r++) begin
            int v;
            do_reset();
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(200, 700));
            enter_preset(v);
            for (int c = 0; c < 500; c++) begin
                logic [5:0] k;
                k[0] = ($urandom_range(0, 7) == 0);
                k[1] = ($urandom_range(0, 7) == 0);
                k[2] = ($urandom_range(0, 7) == 0);
                k[3] = ($urandom_range(0, 7) == 0);
                k[4] = ($urandom_range(0, 15) == 0);
                k[5] = ($urandom_range(0, 63) == 0);
                cyc(k, ($urandom_range(0, 499) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
